// File: rtl/mux_pkg.sv
// Shared types and default sizing for the arbitrated N-channel multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_RR  = 1'b0,
        MODE_FIX = 1'b1
    } mux_mode_e;

    localparam int MUX_N  = 8;
    localparam int MUX_CH = 4;

endpackage

// File: rtl/rr_pick_n.sv
// Rotating priority encoder: the first set request at or after ptr (mod ch) wins.
module rr_pick_n #(
    parameter  int ch      = 4,
    localparam int address = $clog2(ch)
) (
    input  logic [ch-1:0]      req,
    input  logic [address-1:0] ptr,
    output logic               found,
    output logic [address-1:0] idx
);

    logic [address-1:0] off;
    logic [address-1:0] cand;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        off   = '0;
        cand  = '0;
        for (int i = ch - 1; i >= 0; i--) begin
            off  = address'(i);
            cand = ptr + off;
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/muxn_arb_n.sv
// N-channel arbitrated multiplexer: round-robin or fixed select feeding a
// one-entry output register with valid/ready on every channel and the output.
module muxn_arb_n
    import mux_pkg::*;
#(
    parameter  int n       = MUX_N,
    parameter  int ch      = MUX_CH,
    localparam int address = $clog2(ch)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [n-1:0]        data_i [0:ch-1],
    input  logic [ch-1:0]       valid_i,
    output logic [ch-1:0]       ready_o,
    input  logic                mode_i,
    input  logic [address-1:0]  sel_i,
    output logic [n-1:0]        data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [address-1:0]  grant_o
);

    // Handshake: a word moves on any edge where valid and ready are both high on
    // that link; valid never waits on ready, and ready_o may depend on ready_i
    // but nothing registered (valid_o, data_o) does combinationally.

    mux_mode_e          mode;
    logic [address-1:0] ptr;
    logic               rr_found;
    logic [address-1:0] rr_idx;
    logic               win_found;
    logic [address-1:0] win_idx;
    logic               free;
    logic               accept;

    assign mode = mux_mode_e'(mode_i);
    assign free = !valid_o || ready_i;

    rr_pick_n #(.ch(ch)) u_pick (
        .req   (valid_i),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Fixed mode never falls back to another channel when sel_i is idle.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (mode == MODE_FIX) begin
            win_found = valid_i[sel_i];
            win_idx   = sel_i;
        end else begin
            win_found = rr_found;
            win_idx   = rr_idx;
        end
    end

    assign accept = win_found && free && !rst_i;

    always_comb begin
        ready_o = '0;
        if (accept) begin
            ready_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            grant_o <= '0;
            ptr     <= '0;
        end else begin
            if (accept) begin
                data_o  <= data_i[win_idx];
                grant_o <= win_idx;
                valid_o <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr <= win_idx + address'(1);
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_arb_n.sv
// Directed self-checking bench for muxn_arb_n with ch=4, n=8.
module tb_muxn_arb_n;

    localparam int N  = 8;
    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  data_i [0:CH-1];
    logic [CH-1:0] valid_i;
    logic [CH-1:0] ready_o;
    logic          mode;
    logic [1:0]    sel;
    logic [N-1:0]  data_o;
    logic          valid_o;
    logic          ready_i;
    logic [1:0]    grant_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    muxn_arb_n #(.n(N), .ch(CH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode),
        .sel_i   (sel),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .grant_o (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int i = 0; i < CH; i++) data_i[i] = 8'hA0 + 8'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; ready_i = 1'b1; valid_i = 4'b1111;
        load_a();
        tick();
        tick();
        total_cnt++;
        if (ready_o !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", ready_o); else pass_cnt++;
        total_cnt++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else pass_cnt++;
        total_cnt++;
        if (data_o !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_o); else pass_cnt++;
        total_cnt++;
        if (grant_o !== 2'd0) $display("FAIL reset_grant got=%0d exp=0", grant_o); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", ready_o); else pass_cnt++;
    endtask

    task automatic test_rr_fairness();
        logic [7:0] exp_d;
        logic [1:0] exp_g;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_g = 2'(k % 4);
            exp_d = 8'hA0 + 8'(exp_g);
            total_cnt++;
            if (data_o !== exp_d) $display("FAIL rr_data[%0d] got=%h exp=%h", k, data_o, exp_d); else pass_cnt++;
            total_cnt++;
            if (grant_o !== exp_g) $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, grant_o, exp_g); else pass_cnt++;
            total_cnt++;
            if (valid_o !== 1'b1) $display("FAIL rr_valid[%0d] got=%b exp=1", k, valid_o); else pass_cnt++;
        end
    endtask

    task automatic test_back_pressure();
        tick();
        tick();
        total_cnt++;
        if (data_o !== 8'hA2) $display("FAIL bp_setup got=%h exp=a2", data_o); else pass_cnt++;
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (ready_o !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", k, ready_o); else pass_cnt++;
            tick();
            total_cnt++;
            if (data_o !== 8'hA2 || grant_o !== 2'd2 || valid_o !== 1'b1)
                $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=a2/2/1", k, data_o, grant_o, valid_o);
            else pass_cnt++;
        end
        ready_i = 1'b1;
        #1;
        total_cnt++;
        if (ready_o !== 4'b1000) $display("FAIL bp_release_ready got=%b exp=1000", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (data_o !== 8'hA3 || grant_o !== 2'd3) $display("FAIL bp_next got=%h/%0d exp=a3/3", data_o, grant_o); else pass_cnt++;
    endtask

    task automatic test_wrap_skip();
        tick(); tick(); tick();
        total_cnt++;
        if (grant_o !== 2'd2) $display("FAIL skip_setup got=%0d exp=2", grant_o); else pass_cnt++;
        valid_i = 4'b0010;
        data_i[1] = 8'h55;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0010) $display("FAIL skip_ready got=%b exp=0010", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (data_o !== 8'h55 || grant_o !== 2'd1) $display("FAIL skip_data got=%h/%0d exp=55/1", data_o, grant_o); else pass_cnt++;
        valid_i = 4'b1111;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0100) $display("FAIL skip_ptr got=%b exp=0100", ready_o); else pass_cnt++;
        valid_i = 4'b0100;
        tick();
        valid_i = 4'b0001;
        data_i[0] = 8'h0F;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0001) $display("FAIL wrap_ready got=%b exp=0001", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (data_o !== 8'h0F || grant_o !== 2'd0) $display("FAIL wrap_data got=%h/%0d exp=0f/0", data_o, grant_o); else pass_cnt++;
        valid_i = 4'b1111;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0010) $display("FAIL wrap_ptr got=%b exp=0010", ready_o); else pass_cnt++;
    endtask

    task automatic test_fixed_mode();
        mode = 1'b1; sel = 2'd2; valid_i = 4'b1011;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0000) $display("FAIL fix_idle_ready got=%b exp=0000", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (valid_o !== 1'b0) $display("FAIL fix_no_xfer got=%b exp=0", valid_o); else pass_cnt++;
        valid_i = 4'b1111;
        data_i[2] = 8'h3C;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0100) $display("FAIL fix_ready got=%b exp=0100", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (data_o !== 8'h3C || grant_o !== 2'd2 || valid_o !== 1'b1)
            $display("FAIL fix_data got=%h/%0d/%b exp=3c/2/1", data_o, grant_o, valid_o);
        else pass_cnt++;
        mode = 1'b0;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0010) $display("FAIL fix_ptr_kept got=%b exp=0010", ready_o); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        ready_i = 1'b0;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0000) $display("FAIL mid_bp_ready got=%b exp=0000", ready_o); else pass_cnt++;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ready_o !== 4'b0000) $display("FAIL mid_rst_ready got=%b exp=0000", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || grant_o !== 2'd0)
            $display("FAIL mid_rst_state got=%b/%h/%0d exp=0/00/0", valid_o, data_o, grant_o);
        else pass_cnt++;
        rst = 1'b0;
        ready_i = 1'b1;
        load_a();
        #1;
        total_cnt++;
        if (ready_o !== 4'b0001) $display("FAIL mid_ptr got=%b exp=0001", ready_o); else pass_cnt++;
        tick();
        total_cnt++;
        if (data_o !== 8'hA0 || grant_o !== 2'd0) $display("FAIL mid_resume got=%h/%0d exp=a0/0", data_o, grant_o); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; ready_i = 1'b1; valid_i = '0;
        load_a();
        #1;
        test_reset();
        test_rr_fairness();
        test_back_pressure();
        test_wrap_skip();
        test_fixed_mode();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muxn_arb_n.md
# muxn_arb_n

Parametrised N-channel arbitrated multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output. Selects one of `ch` requesting channels per cycle, either round-robin or by an explicit select, and forwards its word through a one-entry output register that holds under back-pressure. Sits wherever several producers share one downstream consumer, such as datapath result buses or memory request ports.

## Interface
- `n`, 8, data width in bits.
- `ch`, 4, channel count; power of two, ≥2.
- `address`, `$clog2(ch)`, select/grant index width; derived, never overridden.

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `data_i`  in  n × [0:ch-1]  unpacked array of channel data words.
- `valid_i`  in  ch  per-channel request; bit k belongs to `data_i[k]`.
- `ready_o`  out  ch  per-channel accept; at most one bit set per cycle.
- `mode_i`  in  1  0 = round-robin, 1 = fixed select.
- `sel_i`  in  address  channel index used in fixed mode.
- `data_o`  out  n  registered output word.
- `valid_o`  out  1  output register holds a word.
- `ready_i`  in  1  downstream accept.
- `grant_o`  out  address  source channel of the current `data_o`.

## Operation
- Input transfer on channel k: `valid_i[k] & ready_o[k]` at a rising edge. Output transfer: `valid_o & ready_i`.
- `free = !valid_o | ready_i`. No channel is accepted when `free` = 0.
- Round-robin mode: the pointer `ptr` (address bits) holds the highest-priority index. Scan order is ptr, ptr+1, …, ptr+ch-1, all mod ch. The first channel with `valid_i` set wins.
- Fixed mode: the winner is `sel_i` only if `valid_i[sel_i]` = 1. Otherwise there is no winner and other channels are never granted.
- `ready_o[w] = free` for winner w. All other `ready_o` bits are 0. `ready_o` is combinational from `valid_i`, `mode_i`, `sel_i`, `ptr`, `valid_o` and `ready_i`.
- On an input transfer from w: `data_o <= data_i[w]`, `grant_o <= w`, `valid_o <= 1`. In round-robin mode, `ptr <= w+1` (wraps ch-1 → 0).
- Output transfer with no input transfer in the same cycle: `valid_o <= 0`. `data_o` and `grant_o` keep their stale values.
- Output and input transfer in the same cycle: the register is reloaded and `valid_o` stays 1. This gives full throughput, 1 word/cycle.
- `ptr` changes only on a round-robin-mode transfer. It is kept across mode switches.
- A `mode_i` or `sel_i` change takes effect in the same cycle's arbitration. A word already in the output register is unaffected.

## Timing
- Reset (`rst_i` high at an edge): `valid_o`=0, `data_o`=0, `grant_o`=0, `ptr`=0. While `rst_i` is high, `ready_o` is forced to 0.
- Reset asserted mid-stream drops any held word. No transfer is counted in the reset cycle.
- Latency: a word accepted at edge t appears on `data_o` with `valid_o`=1 immediately after edge t.
- Back-pressure: while `valid_o & !ready_i`, `data_o`, `grant_o` and `valid_o` hold stable and all `ready_o` bits are 0.
- No combinational path from `ready_i` to `valid_o` or `data_o`. There is a path from `ready_i` to `ready_o`.
- Round-robin fairness: with all channels continuously valid and `ready_i` held at 1, grants cycle 0,1,…,ch-1,0,…
- Wrap boundary: with ptr = ch-1 and only channel 0 valid, channel 0 is granted and ptr becomes 1.

## Structure
- Package `mux_pkg` contains:
  - typedef `mux_mode_e` {MODE_RR = 1'b0, MODE_FIX = 1'b1};
  - default constants `MUX_N = 8` and `MUX_CH = 4`.
- Sub-module `rr_pick_n #(ch)`: combinational rotating priority encoder.
  - Inputs: request vector and `ptr`.
  - Outputs: `found` and `idx`.
  - Instantiated once.
- The top level holds `ptr`, the output register, mode gating and the `ready_o` decode.

## Test plan
Parameters for all scenarios: ch=4, n=8.
1. Reset: hold `rst_i` 2 cycles with all `valid_i`=1 → `ready_o`=0000, `valid_o`=0, `data_o`=0x00, `grant_o`=0. After release, first grant is channel 0.
2. Round-robin fairness: `data_i`={0xA0,0xA1,0xA2,0xA3}, all valid, `ready_i`=1, mode 0 → `data_o` sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles. `valid_o` stays 1.
3. Back-pressure: deassert `ready_i` for 3 cycles while `data_o`=0xA2 → `data_o`=0xA2, `grant_o`=2, `ready_o`=0000 throughout. After `ready_i`=1, next word is 0xA3.
4. Wrap and skip: ptr=3, only `valid_i[1]`=1 with 0x55 → `ready_o`=0010, next `data_o`=0x55, `grant_o`=1, then ptr=2.
5. Fixed mode: mode 1, `sel_i`=2, `valid_i`=1011 → `ready_o`=0000, no transfer. Setting `valid_i[2]`=1 with 0x3C → `ready_o`=0100, `data_o`=0x3C, ptr unchanged.
6. Reset mid-stream: assert `rst_i` while `valid_o`=1 and `ready_i`=0 → next cycle `valid_o`=0, `data_o`=0x00, ptr=0. The held word is never delivered.
